// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule for the inverse cipher.
// Loads the round-10 key and walks the schedule backwards, presenting round
// keys 10..0 one at a time on a valid/ready handshake.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   start     begin request, honoured only when idle
//   key_last  round-10 key (w0 in [127:96], w3 in [31:0])
//   rk        current round key
//   rk_round  round index of rk
//   rk_valid  rk / rk_round valid
//   rk_ready  consumer accept
//   busy      high from accepted start until done
//   done      one-cycle pulse after round 0 is accepted
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// PRESENT | rk offered to consumer, held until handshake
// SUB     | subWord output valid, step rk back by one round

// Four S-box lookups with one registered stage; intentionally no reset.
module subWord (
  input  logic        clk,
  input  logic [31:0] a,
  output logic [31:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  always_ff @(posedge clk) begin
    y <= {sb(a[31:24]), sb(a[23:16]), sb(a[15:8]), sb(a[7:0])};
  end

endmodule

module aes_inv_key_sched (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_last,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_SUB} state_t;

  state_t         r_state, w_state_nxt;
  logic [127:0]   r_rk, w_rk_nxt;
  logic [3:0]     r_round, w_round_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;

  logic [31:0]    w_t;
  logic [31:0]    w_sub_a;
  logic [31:0]    w_sub_y;
  logic [7:0]     w_rcon;
  logic [127:0]   w_rk_prev;
  logic           w_hs;

  // w3 of the previous round is w3^w2 of this one; its RotWord feeds subWord.
  // rk is stable through PRESENT, so y is ready by the SUB cycle.
  assign w_t     = r_rk[31:0] ^ r_rk[63:32];
  assign w_sub_a = {w_t[23:0], w_t[31:24]};

  subWord u_sub (
    .clk (clk),
    .a   (w_sub_a),
    .y   (w_sub_y)
  );

  always_comb begin
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_rk_prev = {r_rk[127:96] ^ w_sub_y ^ {w_rcon, 24'h0},
                      r_rk[127:96] ^ r_rk[95:64],
                      r_rk[95:64]  ^ r_rk[63:32],
                      w_t};

  assign w_hs = r_valid & rk_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rk    <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rk    <= w_rk_nxt;
      r_round <= w_round_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_round_nxt = r_round;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rk_nxt    = key_last;
          w_round_nxt = 4'd10;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (r_round == 4'd0) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SUB;
          end
        end
      end
      S_SUB: begin
        // Only reached with r_round > 0, so the decrement never wraps.
        w_rk_nxt    = w_rk_prev;
        w_round_nxt = r_round - 4'd1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_PRESENT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rk       = r_rk;
  assign rk_round = r_round;
  assign rk_valid = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative reverse AES-128 key schedule for the decryption datapath.
- Takes the round-10 key, which key expansion produces, and emits round keys 10, 9, …, 0 in that order, which is the order inverse cipher rounds consume them.
- Reuses the existing synchronous `subWord` block (4 S-box lookups, 1-cycle registered latency) for the SubWord(RotWord()) term.
- Sits between key-expansion output storage and the inverse-cipher round controller, with a valid/ready handshake on round keys.

Parameters:
- none (AES-128 only; Rcon table is fixed internally)

Ports:
- `clk`       in   1    system clock, all state on rising edge
- `reset_n`   in   1    asynchronous active-low reset
- `start`     in   1    one-cycle request to begin; sampled only in IDLE
- `key_last`  in   128  round-10 key, w0 in [127:96], w3 in [31:0]; sampled on accepted start
- `rk`        out  128  current round key, same word order
- `rk_round`  out  4    round index of `rk` (10 down to 0)
- `rk_valid`  out  1    `rk` / `rk_round` valid
- `rk_ready`  in   1    consumer accepts `rk` when `rk_valid` && `rk_ready` at a rising edge
- `busy`      out  1    high from accepted start until done
- `done`      out  1    one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, `reset_n`=0) forces:
  - `rk`=0, `rk_round`=0, `rk_valid`=0, `busy`=0, `done`=0, state=IDLE.
  - `subWord` has no reset; its output is don't-care until it is used.
- Reset asserted mid-operation aborts immediately. No `done` is produced, and the next start begins fresh.
- States: IDLE, PRESENT, SUB.
- IDLE:
  - On `start`=1: `rk`<=`key_last`, `rk_round`<=10, `busy`<=1, go to PRESENT.
  - `rk_valid` goes high the cycle after start.
- PRESENT:
  - `rk_valid`=1; `rk` and `rk_round` are held stable while `rk_ready`=0, with no limit on stall length.
  - On a handshake with `rk_round`=0: `rk_valid`<=0, `busy`<=0, `done`<=1 for exactly one cycle, go to IDLE.
  - On a handshake with `rk_round`>0: `rk_valid`<=0, go to SUB.
- SUB (exactly 1 cycle):
  - `subWord` input `a` is driven combinationally from `rk` at all times: a = RotWord(t), where t = rk[31:0]^rk[63:32] and RotWord(x) = {x[23:0], x[31:24]}.
  - Because `rk` has been stable for at least one edge, `subWord` output `y` is valid during SUB.
  - At the end of SUB, with w0..w3 the current words:
    - w3' = w3^w2
    - w2' = w2^w1
    - w1' = w1^w0
    - w0' = w0 ^ y ^ {Rcon(`rk_round`), 24'h0}
  - Then load `rk`<={w0',w1',w2',w3'}, `rk_round`<=`rk_round`-1, go to PRESENT.
- Rcon(r) for r=1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - `rk_round` never wraps below 0.
  - Rcon(0) is never used.
- Throughput with `rk_ready` held 1:
  - Each round takes 2 cycles.
  - Start accepted at edge 0; round 10 valid in cycle 1; round k valid in cycle 1+2·(10−k); round 0 valid in cycle 21.
  - `done` is high in cycle 22.
- `start` while not IDLE is ignored, and `key_last` is not resampled.
- Simultaneous handshake on round 0 and `start` high: the start is ignored. A new start is accepted only in IDLE, earliest the `done` cycle.
- `rk_ready` high while `rk_valid`=0 has no effect.

Test Plan:
1. Reset then a FIPS-197 run:
   - Stimulus: `key_last`=d014f9a8c9ee2589e13f0cc8b6630ca6, `start` pulse, `rk_ready`=1.
   - Required: round 10 = `key_last`; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
   - Required: `rk_round` decrements 10→0, `done` is high for one cycle at cycle 22.
2. Internal probe on the same run:
   - In the SUB cycle of the round 1→0 step, `subWord` a = cf4f3c09 and y = 8a84eb01.
3. Back-pressure:
   - Stimulus: `rk_ready` randomly low, including a 5-cycle stall on round 7.
   - Required: `rk`, `rk_round` and `rk_valid` stay stable during the stall; the key sequence is identical to scenario 1; exactly 11 handshakes occur.
4. Start while busy:
   - Stimulus: `start` with a different `key_last` at round 5.
   - Required: no effect; the output sequence is unchanged; `busy` stays 1.
5. Reset mid-operation:
   - Stimulus: assert `reset_n`=0 asynchronously (between edges) during round 4 PRESENT.
   - Required: all outputs read 0 immediately, no `done` pulse.
   - Then: a new start with key 0 → round 10 = 0, and the next round key = 0x62636363626363636263636362636363 ^ derived chain (compare with the golden model).
6. All-zero round-10 key:
   - Stimulus: `key_last`=0, run to completion.
   - Required: the round-9 value matches the golden model, and completion takes exactly 22 cycles after start with `rk_ready`=1.
